regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 126 ++++++++++++
 tb/tb_regfile_sb.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Flop-based register file with two combinational read ports, one write port
// and a per-entry busy scoreboard (set by producer issue, cleared by write).
module regfile_sb #(
   parameter int DW       = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [AW-1:0] raddr1,
   output logic [DW-1:0] rdata1,
   output logic          rbusy1,
   input  logic [AW-1:0] raddr2,
   output logic [DW-1:0] rdata2,
   output logic          rbusy2,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   output logic          busy_any
);

   localparam int DEPTH = 1 << AW;
   localparam bit ZR    = (ZERO_REG != 0);
   localparam bit BP    = (BYPASS != 0);

   logic [DW-1:0]    entry_data [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;
   logic             busy_any_q;
   logic             busy_any_d;
   logic             wr_drop;
   logic             wr_keep;

   assign wr_drop = ZR && (waddr == '0);
   assign wr_keep = we && !wr_drop;

   // Entry 0 is hardwired when ZERO_REG is set, so it never stores data or busy.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [AW-1:0] IDX = AW'(gi);
      if (ZR && gi == 0) begin : g_zero
         assign entry_data[gi] = '0;
         assign busy_d[gi]     = 1'b0;
      end else begin : g_live
         logic [DW-1:0] data_q;
         logic [DW-1:0] data_d;
         logic          busy_nx;

         // Clear first, then set, so a same-entry set wins over the write's clear.
         always_comb begin
            data_d  = data_q;
            busy_nx = busy_q[gi];
            if (we && (waddr == IDX)) begin
               data_d  = wdata;
               busy_nx = 1'b0;
            end
            if (set_en && (set_addr == IDX)) begin
               busy_nx = 1'b1;
            end
         end

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               data_q <= '0;
            end else begin
               data_q <= data_d;
            end
         end

         assign entry_data[gi] = data_q;
         assign busy_d[gi]     = busy_nx;
      end
   end

   assign busy_any_d = |busy_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_q     <= '0;
         busy_any_q <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         busy_any_q <= busy_any_d;
      end
   end

   logic [AW-1:0] rd_addr [2];
   logic [DW-1:0] rd_data [2];
   logic          rd_busy [2];

   assign rd_addr[0] = raddr1;
   assign rd_addr[1] = raddr2;

   // Outputs are forced quiet during reset so a bypassed write cannot leak out.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rport
      logic          fwd_hit;
      logic [DW-1:0] data_c;
      logic          busy_c;

      assign fwd_hit = BP && we && (waddr == rd_addr[gi]);

      always_comb begin
         data_c = entry_data[rd_addr[gi]];
         busy_c = busy_q[rd_addr[gi]] && !fwd_hit;
         if (fwd_hit && wr_keep) begin
            data_c = wdata;
         end
         if (!resetn) begin
            data_c = '0;
            busy_c = 1'b0;
         end
      end

      assign rd_data[gi] = data_c;
      assign rd_busy[gi] = busy_c;
   end

   assign rdata1   = rd_data[0];
   assign rbusy1   = rd_busy[0];
   assign rdata2   = rd_data[1];
   assign rbusy2   = rd_busy[1];
   assign busy_any = busy_any_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, reset and bypass sequences,
// randomized run against an array model, and a 64-bit/8-entry sweep.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        resetn;
   logic [4:0]  raddr1, raddr2, waddr, set_addr;
   logic [31:0] wdata;
   logic        we, set_en;

   logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
   logic        rb1_b, rb2_b, ba_b, rb1_n, rb2_n, ba_n;

   logic [2:0]  w_raddr1, w_raddr2, w_waddr, w_set_addr;
   logic [63:0] w_wdata, w_rd1, w_rd2;
   logic        w_we, w_set_en, w_rb1, w_rb2, w_ba;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_sb #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) u_byp (
      .clk(clk), .resetn(resetn),
      .raddr1(raddr1), .rdata1(rd1_b), .rbusy1(rb1_b),
      .raddr2(raddr2), .rdata2(rd2_b), .rbusy2(rb2_b),
      .we(we), .waddr(waddr), .wdata(wdata),
      .set_en(set_en), .set_addr(set_addr), .busy_any(ba_b)
   );

   regfile_sb #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(0)) u_nob (
      .clk(clk), .resetn(resetn),
      .raddr1(raddr1), .rdata1(rd1_n), .rbusy1(rb1_n),
      .raddr2(raddr2), .rdata2(rd2_n), .rbusy2(rb2_n),
      .we(we), .waddr(waddr), .wdata(wdata),
      .set_en(set_en), .set_addr(set_addr), .busy_any(ba_n)
   );

   regfile_sb #(.DW(64), .AW(3), .ZERO_REG(0), .BYPASS(1)) u_wide (
      .clk(clk), .resetn(resetn),
      .raddr1(w_raddr1), .rdata1(w_rd1), .rbusy1(w_rb1),
      .raddr2(w_raddr2), .rdata2(w_rd2), .rbusy2(w_rb2),
      .we(w_we), .waddr(w_waddr), .wdata(w_wdata),
      .set_en(w_set_en), .set_addr(w_set_addr), .busy_any(w_ba)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        se;
      logic [4:0]  sa;
      logic [4:0]  a1, a2;
      logic [31:0] d1, d2;
      logic        b1, b2, ba;
   } vec_t;

   function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic s, input logic [4:0] sa,
                               input logic [4:0] a1, input logic [4:0] a2,
                               input logic [31:0] d1, input logic b1,
                               input logic [31:0] d2, input logic b2, input logic ba);
      vec_t v;
      v.we = w;  v.wa = wa; v.wd = wd; v.se = s; v.sa = sa;
      v.a1 = a1; v.a2 = a2; v.d1 = d1; v.b1 = b1; v.d2 = d2; v.b2 = b2; v.ba = ba;
      return v;
   endfunction

   // Reference model: plain arrays updated by the architectural rules.
   logic [31:0] m_mem  [32];
   bit          m_busy [32];

   function automatic logic [31:0] m_rdata(input logic [4:0] a, input bit byp);
      if (a == 0) return 32'h0;
      if (byp && we && waddr == a) return wdata;
      return m_mem[a];
   endfunction

   function automatic logic m_rbusy(input logic [4:0] a, input bit byp);
      if (a == 0) return 1'b0;
      return m_busy[a] && !(byp && we && waddr == a);
   endfunction

   function automatic logic m_any();
      for (int i = 0; i < 32; i++) if (m_busy[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_edge();
      if (we && waddr != 0) m_mem[waddr] = wdata;
      if (we) m_busy[waddr] = 1'b0;
      if (set_en && set_addr != 0) m_busy[set_addr] = 1'b1;
   endtask

   task automatic idle();
      we = 1'b0; waddr = '0; wdata = '0; set_en = 1'b0; set_addr = '0;
   endtask

   function automatic logic [63:0] pat(input int i);
      logic [31:0] a;
      a = 32'hA500_0000 + 32'(i * 32'h0001_0203);
      return {a, ~a ^ 32'h0F0F_0000};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   vec_t tbl [17];

   initial begin
      tbl[0]  = mk(0, 0,  32'h0,        0, 0,  0,  0,  32'h0,        0, 32'h0,        0, 0);
      tbl[1]  = mk(1, 3,  32'h12345678, 0, 0,  3,  3,  32'h12345678, 0, 32'h12345678, 0, 0);
      tbl[2]  = mk(0, 0,  32'h0,        0, 0,  3,  0,  32'h12345678, 0, 32'h0,        0, 0);
      tbl[3]  = mk(1, 0,  32'hFFFFFFFF, 0, 0,  0,  0,  32'h0,        0, 32'h0,        0, 0);
      tbl[4]  = mk(0, 0,  32'h0,        0, 0,  3,  0,  32'h12345678, 0, 32'h0,        0, 0);
      tbl[5]  = mk(0, 0,  32'h0,        1, 7,  7,  0,  32'h0,        0, 32'h0,        0, 0);
      tbl[6]  = mk(0, 0,  32'h0,        0, 0,  7,  7,  32'h0,        1, 32'h0,        1, 1);
      tbl[7]  = mk(1, 7,  32'hA5A5A5A5, 0, 0,  7,  3,  32'hA5A5A5A5, 0, 32'h12345678, 0, 1);
      tbl[8]  = mk(0, 0,  32'h0,        0, 0,  7,  0,  32'hA5A5A5A5, 0, 32'h0,        0, 0);
      tbl[9]  = mk(1, 9,  32'h0BADF00D, 1, 9,  9,  9,  32'h0BADF00D, 0, 32'h0BADF00D, 0, 0);
      tbl[10] = mk(0, 0,  32'h0,        0, 0,  9,  9,  32'h0BADF00D, 1, 32'h0BADF00D, 1, 1);
      tbl[11] = mk(0, 0,  32'h0,        1, 0,  0,  0,  32'h0,        0, 32'h0,        0, 1);
      tbl[12] = mk(0, 0,  32'h0,        0, 0,  0,  9,  32'h0,        0, 32'h0BADF00D, 1, 1);
      tbl[13] = mk(1, 9,  32'h11112222, 1, 12, 9,  12, 32'h11112222, 0, 32'h0,        0, 1);
      tbl[14] = mk(0, 0,  32'h0,        0, 0,  9,  12, 32'h11112222, 0, 32'h0,        1, 1);
      tbl[15] = mk(1, 12, 32'h00000005, 0, 0,  12, 31, 32'h00000005, 0, 32'h0,        0, 1);
      tbl[16] = mk(0, 0,  32'h0,        0, 0,  12, 3,  32'h00000005, 0, 32'h12345678, 0, 0);

      resetn = 1'b0;
      idle();
      raddr1 = '0; raddr2 = '0;
      w_we = 1'b0; w_waddr = '0; w_wdata = '0; w_set_en = 1'b0; w_set_addr = '0;
      w_raddr1 = '0; w_raddr2 = '0;

      // Reset held: a bypassable write must not appear on the outputs.
      #3;
      we = 1'b1; waddr = 5'd4; wdata = 32'hFFFF0000; raddr1 = 5'd4;
      #1;
      chk("in_reset_rdata1", rd1_b, 32'h0);
      chk("in_reset_busy_any", ba_b, 1'b0);
      @(negedge clk); idle(); raddr1 = '0;
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 17; i++) begin
         we = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd;
         set_en = tbl[i].se; set_addr = tbl[i].sa;
         raddr1 = tbl[i].a1; raddr2 = tbl[i].a2;
         @(negedge clk);
         $display("vec %0d: we=%0b wa=%0d wd=%h se=%0b sa=%0d ra1=%0d ra2=%0d -> rd1=%h rb1=%0b rd2=%h rb2=%0b ba=%0b",
                  i, we, waddr, wdata, set_en, set_addr, raddr1, raddr2, rd1_b, rb1_b, rd2_b, rb2_b, ba_b);
         chk($sformatf("vec%0d_rdata1", i), rd1_b, tbl[i].d1);
         chk($sformatf("vec%0d_rbusy1", i), rb1_b, tbl[i].b1);
         chk($sformatf("vec%0d_rdata2", i), rd2_b, tbl[i].d2);
         chk($sformatf("vec%0d_rbusy2", i), rb2_b, tbl[i].b2);
         chk($sformatf("vec%0d_busy_any", i), ba_b, tbl[i].ba);
         @(posedge clk); #1;
      end

      // Mid-operation reset clears contents and busy immediately.
      idle();
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; set_en = 1'b1; set_addr = 5'd6;
      @(posedge clk); #1;
      idle(); raddr1 = 5'd5; raddr2 = 5'd6;
      #1;
      chk("pre_reset_rdata1", rd1_b, 32'hDEADBEEF);
      chk("pre_reset_busy_any", ba_b, 1'b1);
      #1; resetn = 1'b0; #1;
      chk("async_reset_rdata1", rd1_b, 32'h0);
      chk("async_reset_rdata1_nob", rd1_n, 32'h0);
      chk("async_reset_rbusy2", rb2_b, 1'b0);
      chk("async_reset_busy_any", ba_b, 1'b0);
      we = 1'b1; waddr = 5'd5; wdata = 32'hCAFEF00D; set_en = 1'b1; set_addr = 5'd5;
      @(posedge clk); #1;
      chk("reset_ignores_write", rd1_b, 32'h0);
      chk("reset_ignores_set", rb1_b, 1'b0);
      idle();
      @(negedge clk);
      resetn = 1'b1;
      we = 1'b1; waddr = 5'd5; wdata = 32'h600DCAFE;
      @(posedge clk); #1;
      idle();
      #1;
      chk("first_edge_write", rd1_b, 32'h600DCAFE);
      chk("first_edge_write_nob", rd1_n, 32'h600DCAFE);
      chk("post_reset_busy_any", ba_b, 1'b0);

      // No-bypass instance shows old data and keeps busy until the edge.
      @(posedge clk); #1;
      we = 1'b1; waddr = 5'd3; wdata = 32'h12345678; raddr1 = 5'd3; raddr2 = 5'd3;
      @(negedge clk);
      chk("nob_same_cycle_old", rd1_n, 32'h0);
      chk("byp_same_cycle_new", rd1_b, 32'h12345678);
      @(posedge clk); #1;
      idle();
      #1;
      chk("nob_after_edge", rd1_n, 32'h12345678);
      chk("byp_after_edge", rd1_b, 32'h12345678);
      set_en = 1'b1; set_addr = 5'd7; raddr1 = 5'd7;
      @(posedge clk); #1;
      idle(); we = 1'b1; waddr = 5'd7; wdata = 32'h77777777;
      @(negedge clk);
      chk("nob_write_cycle_busy", rb1_n, 1'b1);
      chk("byp_write_cycle_busy", rb1_b, 1'b0);
      chk("nob_write_cycle_busy_any", ba_n, 1'b1);
      @(posedge clk); #1;
      idle();
      #1;
      chk("nob_cleared_busy", rb1_n, 1'b0);
      chk("nob_cleared_busy_any", ba_n, 1'b0);

      for (int i = 0; i < 32; i++) begin
         m_mem[i] = 32'h0; m_busy[i] = 1'b0;
      end
      m_mem[5] = 32'h600DCAFE; m_mem[3] = 32'h12345678; m_mem[7] = 32'h77777777;

      for (int n = 0; n < 400; n++) begin
         we       = ($urandom_range(0, 1) == 1);
         waddr    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         wdata    = $urandom;
         set_en   = ($urandom_range(0, 2) == 0);
         set_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 7));
         raddr1   = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 7));
         raddr2   = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 7));
         @(negedge clk);
         $display("rnd %0d: we=%0b wa=%0d wd=%h se=%0b sa=%0d ra1=%0d ra2=%0d",
                  n, we, waddr, wdata, set_en, set_addr, raddr1, raddr2);
         chk("rnd_byp_rdata1", rd1_b, m_rdata(raddr1, 1'b1));
         chk("rnd_byp_rdata2", rd2_b, m_rdata(raddr2, 1'b1));
         chk("rnd_byp_rbusy1", rb1_b, m_rbusy(raddr1, 1'b1));
         chk("rnd_byp_rbusy2", rb2_b, m_rbusy(raddr2, 1'b1));
         chk("rnd_byp_busy_any", ba_b, m_any());
         chk("rnd_nob_rdata1", rd1_n, m_rdata(raddr1, 1'b0));
         chk("rnd_nob_rdata2", rd2_n, m_rdata(raddr2, 1'b0));
         chk("rnd_nob_rbusy1", rb1_n, m_rbusy(raddr1, 1'b0));
         chk("rnd_nob_rbusy2", rb2_n, m_rbusy(raddr2, 1'b0));
         chk("rnd_nob_busy_any", ba_n, m_any());
         m_edge();
         @(posedge clk); #1;
      end
      idle();

      // Wide, shallow instance with entry 0 writable.
      for (int i = 0; i < 8; i++) begin
         w_we = 1'b1; w_waddr = 3'(i); w_wdata = pat(i);
         @(posedge clk); #1;
      end
      w_we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         w_raddr1 = 3'(i); w_raddr2 = 3'(7 - i);
         @(negedge clk);
         $display("wide %0d: rd1=%h rd2=%h", i, w_rd1, w_rd2);
         chk($sformatf("wide_rdata1_%0d", i), w_rd1, pat(i));
         chk($sformatf("wide_rdata2_%0d", i), w_rd2, pat(7 - i));
         @(posedge clk); #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
